// File: rtl/fft_input_loader.sv
// rtl/fft_input_loader.sv - streams one frame of samples into FFT RAM at bit-reversed addresses,
// then starts the core and stalls the stream until it reports done.
module fft_input_loader #(
  parameter int N     = 1024,
  parameter int LOG2N = 10,
  parameter int DW    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DW-1:0]    s_data,
  input  logic             s_last,
  output logic             ram_we,
  output logic [LOG2N-1:0] ram_addr,
  output logic [DW-1:0]    ram_wdata,
  output logic             fft_start,
  input  logic             fft_done,
  output logic             busy,
  output logic             frame_err
);

  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT_DONE} state_t;

  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

  state_t           state, state_nxt;
  logic [LOG2N-1:0] cnt, cnt_nxt;
  logic             hs;
  logic             err_nxt;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  assign s_ready = (state == LOAD);
  assign busy    = (state == START) || (state == WAIT_DONE);
  assign hs      = s_valid && s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // An early last restarts the frame in place; the full-count sample always closes the frame.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_nxt   = 1'b0;
    case (state)
      IDLE: state_nxt = LOAD;
      LOAD: begin
        if (hs) begin
          if (cnt == LAST_IDX) begin
            state_nxt = START;
            cnt_nxt   = '0;
            err_nxt   = !s_last;
          end else if (s_last) begin
            cnt_nxt = '0;
            err_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      START:     state_nxt = WAIT_DONE;
      WAIT_DONE: if (fft_done) state_nxt = LOAD;
      default:   state_nxt = IDLE;
    endcase
  end

  // fft_start trails the START cycle so the final RAM write lands first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      fft_start <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      ram_we    <= hs;
      fft_start <= (state == START);
      frame_err <= err_nxt;
      if (hs) begin
        ram_addr  <= bitrev(cnt);
        ram_wdata <= s_data;
      end
    end
  end

endmodule

// File: tb/tb_fft_input_loader.sv
// tb/tb_fft_input_loader.sv - randomized scenario bench for fft_input_loader against a frame-position model.
module tb_fft_input_loader;

  localparam int N     = 1024;
  localparam int LOG2N = 10;
  localparam int DW    = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [DW-1:0]    s_data = '0;
  logic             s_last = 1'b0;
  logic             ram_we;
  logic [LOG2N-1:0] ram_addr;
  logic [DW-1:0]    ram_wdata;
  logic             fft_start;
  logic             fft_done = 1'b0;
  logic             busy;
  logic             frame_err;

  fft_input_loader #(.N(N), .LOG2N(LOG2N), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .fft_start(fft_start), .fft_done(fft_done), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: position within the current frame and expected effects.
  int pos = 0;
  int exp_err = 0;
  int exp_start = 0;
  logic [LOG2N+DW-1:0] exp_q[$];
  logic [LOG2N+DW-1:0] obs_q[$];

  // Monitor state, sampled on the falling edge.
  int cyc = 0;
  bit hs_prev = 1'b0;
  int n_start = 0, n_ferr = 0, bad_we = 0;
  int last_hs_edge = 0, start_cyc = 0, err_cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (ram_we) begin
      obs_q.push_back({ram_addr, ram_wdata});
      if (!hs_prev) bad_we++;
    end
    if (fft_start) begin n_start++; start_cyc = cyc; end
    if (frame_err) begin n_ferr++; err_cyc = cyc; end
    hs_prev = s_valid && s_ready;
    if (hs_prev) last_hs_edge = cyc + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time_limit_reached vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  function automatic int rev(input int p);
    int r = 0;
    int v = p;
    for (int i = 0; i < LOG2N; i++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic send(input logic [DW-1:0] d, input bit last);
    int budget = 0;
    logic [LOG2N-1:0] a;
    s_valid = 1'b1; s_data = d; s_last = last;
    while (!s_ready && budget < 200) begin @(posedge clk); #2; budget++; end
    if (!s_ready) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout s_ready=%0b required=1", s_ready);
      s_valid = 1'b0; s_last = 1'b0;
      return;
    end
    @(posedge clk); #2;
    s_valid = 1'b0; s_last = 1'b0;
    a = LOG2N'(rev(pos));
    exp_q.push_back({a, d});
    if (pos == N - 1) begin
      pos = 0; exp_start++;
      if (!last) exp_err++;
    end else if (last) begin
      pos = 0; exp_err++;
    end else begin
      pos++;
    end
  endtask

  task automatic done_pulse();
    fft_done = 1'b1;
    @(posedge clk); #2;
    fft_done = 1'b0;
  endtask

  task automatic clear_counts();
    n_start = 0; n_ferr = 0; exp_start = 0; exp_err = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #2;
    n_vec++;
    if ({s_ready, ram_we, ram_addr, ram_wdata, fft_start, busy, frame_err} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got=%h required=0",
               {s_ready, ram_we, ram_addr, ram_wdata, fft_start, busy, frame_err});
    end
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (s_ready !== 1'b0) begin n_err++; $display("FAIL reset_idle_ready got=%0b required=0", s_ready); end
    @(posedge clk); #1;
    n_vec++;
    if (s_ready !== 1'b1) begin n_err++; $display("FAIL reset_load_ready got=%0b required=1", s_ready); end
    #1;
  endtask

  task automatic test_full_frame();
    clear_counts();
    for (int i = 0; i < N; i++) send(DW'(i), i == N - 1);
    idle(3);
    n_vec++;
    if (n_start !== exp_start) begin n_err++; $display("FAIL full_start_count got=%0d required=%0d", n_start, exp_start); end
    n_vec++;
    if (start_cyc !== last_hs_edge + 1) begin n_err++; $display("FAIL full_start_timing got=%0d required=%0d", start_cyc, last_hs_edge + 1); end
    n_vec++;
    if (n_ferr !== 0) begin n_err++; $display("FAIL full_frame_err got=%0d required=0", n_ferr); end
    n_vec++;
    if (obs_q.size() > 3 && obs_q[3][LOG2N+DW-1:DW] !== LOG2N'(768)) begin
      n_err++; $display("FAIL full_addr3 got=%0d required=768", obs_q[3][LOG2N+DW-1:DW]);
    end
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL full_wr_count got=%0d required=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL full_wr[%0d] got=%h required=%h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_pressure();
    int ready_hi = 0;
    s_valid = 1'b1; s_data = $urandom;
    repeat (20) begin
      @(posedge clk); #2;
      if (s_ready) ready_hi++;
    end
    n_vec++;
    if (ready_hi !== 0) begin n_err++; $display("FAIL bp_ready_cycles got=%0d required=0", ready_hi); end
    n_vec++;
    if (obs_q.size() !== 0) begin n_err++; $display("FAIL bp_writes got=%0d required=0", obs_q.size()); end
    s_valid = 1'b0;
    done_pulse();
    n_vec++;
    if (s_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_after_done got=%0b required=1", s_ready); end
    clear_counts();
    send($urandom, 1'b0);
    idle(1);
    n_vec++;
    if (obs_q.size() < 1 || obs_q[0][LOG2N+DW-1:DW] !== '0) begin
      n_err++; $display("FAIL bp_first_addr got=%0d required=0", obs_q.size() ? obs_q[0][LOG2N+DW-1:DW] : LOG2N'('1));
    end
  endtask

  task automatic test_gaps_spurious_done();
    bad_we = 0;
    for (int i = 1; i < N; i++) begin
      if (i < 900) fft_done = 1'($urandom_range(0, 1));
      idle($urandom_range(0, 3));
      fft_done = 1'b0;
      send($urandom, i == N - 1);
    end
    idle(3);
    n_vec++;
    if (bad_we !== 0) begin n_err++; $display("FAIL gap_stray_we got=%0d required=0", bad_we); end
    n_vec++;
    if (n_start !== 1) begin n_err++; $display("FAIL gap_start_count got=%0d required=1", n_start); end
    n_vec++;
    if (n_ferr !== exp_err) begin n_err++; $display("FAIL gap_frame_err got=%0d required=%0d", n_ferr, exp_err); end
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL gap_wr_count got=%0d required=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL gap_wr[%0d] got=%h required=%h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
    done_pulse();
  endtask

  task automatic test_early_last();
    clear_counts();
    for (int i = 0; i < 5; i++) send($urandom, i == 4);
    for (int i = 0; i < N; i++) send($urandom, i == N - 1);
    idle(3);
    n_vec++;
    if (n_ferr !== 1) begin n_err++; $display("FAIL early_frame_err got=%0d required=1", n_ferr); end
    n_vec++;
    if (n_start !== 1) begin n_err++; $display("FAIL early_start_count got=%0d required=1", n_start); end
    n_vec++;
    if (start_cyc !== last_hs_edge + 1) begin n_err++; $display("FAIL early_start_timing got=%0d required=%0d", start_cyc, last_hs_edge + 1); end
    n_vec++;
    if (obs_q.size() > 5 && obs_q[5][LOG2N+DW-1:DW] !== '0) begin
      n_err++; $display("FAIL early_restart_addr got=%0d required=0", obs_q[5][LOG2N+DW-1:DW]);
    end
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL early_wr_count got=%0d required=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL early_wr[%0d] got=%h required=%h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
    done_pulse();
  endtask

  task automatic test_missing_last();
    clear_counts();
    for (int i = 0; i < N; i++) send($urandom, 1'b0);
    idle(3);
    n_vec++;
    if (n_ferr !== exp_err) begin n_err++; $display("FAIL miss_frame_err got=%0d required=%0d", n_ferr, exp_err); end
    n_vec++;
    if (err_cyc !== last_hs_edge) begin n_err++; $display("FAIL miss_err_timing got=%0d required=%0d", err_cyc, last_hs_edge); end
    n_vec++;
    if (n_start !== exp_start) begin n_err++; $display("FAIL miss_start_count got=%0d required=%0d", n_start, exp_start); end
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL miss_wr_count got=%0d required=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL miss_wr[%0d] got=%h required=%h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
    done_pulse();
  endtask

  task automatic test_reset_mid_frame();
    clear_counts();
    for (int i = 0; i < 300; i++) send($urandom | 32'h1, 1'b0);
    idle(2);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL rst_pre_wr_count got=%0d required=%0d", obs_q.size(), exp_q.size()); end
    obs_q.delete(); exp_q.delete();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({s_ready, ram_we, ram_addr, ram_wdata, fft_start, busy, frame_err} !== '0) begin
      n_err++;
      $display("FAIL rst_mid_outputs got=%h required=0",
               {s_ready, ram_we, ram_addr, ram_wdata, fft_start, busy, frame_err});
    end
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    pos = 0;
    idle(1);
    for (int i = 0; i < N; i++) begin
      if (i == N - 1) begin
        n_vec++;
        if (n_start !== 0) begin n_err++; $display("FAIL rst_early_start got=%0d required=0", n_start); end
      end
      send($urandom, i == N - 1);
    end
    idle(3);
    n_vec++;
    if (n_start !== 1) begin n_err++; $display("FAIL rst_start_count got=%0d required=1", n_start); end
    n_vec++;
    if (start_cyc !== last_hs_edge + 1) begin n_err++; $display("FAIL rst_start_timing got=%0d required=%0d", start_cyc, last_hs_edge + 1); end
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL rst_wr_count got=%0d required=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rst_wr[%0d] got=%h required=%h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
    done_pulse();
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_back_pressure();
    test_gaps_spurious_done();
    test_early_last();
    test_missing_last();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
